// File: rtl/reg_bank_arb.sv
// Round-robin write arbiter for two requesters plus a registered read port over a 4-entry register bank.
// Optional feature macro: WRITE_BYPASS_EN forwards a same-edge write to rd_data.
module reg_bank_arb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [1:0]        addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [1:0]        addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              last_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              last_b_q, last_b_d;
  logic              elig_a, elig_b;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  // A request seen while its own grant is high was already consumed at the previous edge.
  always_comb begin
    elig_a    = req_a & ~gnt_a_q;
    elig_b    = req_b & ~gnt_b_q;
    gnt_a_d   = elig_a & (~elig_b | last_b_q);
    gnt_b_d   = elig_b & (~elig_a | ~last_b_q);
    wr_en     = gnt_a_d | gnt_b_d;
    wr_addr   = gnt_b_d ? addr_b : addr_a;
    wr_data   = gnt_b_d ? data_b : data_a;
    last_b_d  = wr_en ? gnt_b_d : last_b_q;
    rd_data_d = regs_q[rd_addr];
`ifdef WRITE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign last_b  = last_b_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_reg_bank_arb.sv
// Scoreboard bench for reg_bank_arb: expected grant order and read values are queued with the stimulus
// and popped against what the DUT produces.
module tb_reg_bank_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [1:0]  addr_a = '0, addr_b = '0, rd_addr = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, last_b;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit is_b;
    int cyc;
  } grant_t;

  grant_t      obs_q[$];
  bit          exp_q[$];
  logic [31:0] rd_exp_q[$];

  reg_bank_arb #(.DATA_W(32), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .rd_addr(rd_addr), .rd_data(rd_data), .last_b(last_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle a grant is high it is logged, so a stretched pulse shows up as an extra entry.
  always @(posedge clk) begin
    #1;
    if (gnt_a === 1'b1) obs_q.push_back('{1'b0, cyc});
    if (gnt_b === 1'b1) obs_q.push_back('{1'b1, cyc});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_a(input logic [1:0] addr, input logic [31:0] data, output bit ok);
    ok = 1'b0; req_a = 1'b1; addr_a = addr; data_a = data;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #1;
      if (gnt_a === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic drive_b(input logic [1:0] addr, input logic [31:0] data, output bit ok);
    ok = 1'b0; req_b = 1'b1; addr_b = addr; data_b = data;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #1;
      if (gnt_b === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    rd_addr = a;
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt_a got=%b exp=0", gnt_a); end
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt_b got=%b exp=0", gnt_b); end
    checks++; if (last_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_last_b got=%b exp=1", last_b); end
    #2 rst_n = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      rd_exp_q.push_back(32'h0);
      do_read(i[1:0], got);
      exp = rd_exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL reset_reg%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL reset_spurious_gnt got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_single_writer();
    bit ok; grant_t g; bit e;
    logic [31:0] got, exp;
    obs_q.delete();
    exp_q.push_back(1'b0);
    drive_a(2'd2, 32'h0000_0005, ok);
    req_a = 1'b0;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_gnt_timeout got=0 exp=1"); end
    @(posedge clk); #1;
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("[TB] FAIL single_gnt_width got=%b exp=0", gnt_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL single_gnt_missing got=none exp=%0d", e); end
      else begin
        g = obs_q.pop_front();
        if (g.is_b !== e) begin errors++; $display("[TB] FAIL single_gnt_who got=%0d exp=%0d", g.is_b, e); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL single_gnt_extra got=%0d exp=0", obs_q.size()); end
    rd_exp_q.push_back(32'h0000_0005);
    do_read(2'd2, got);
    exp = rd_exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL single_read got=%h exp=%h", got, exp); end
  endtask

  task automatic test_simultaneous();
    bit ok_a, ok_b, e; grant_t g; int prev, n;
    logic [31:0] got, exp;
    apply_reset();
    obs_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    fork
      begin drive_a(2'd1, 32'hAAAA_AAAA, ok_a); req_a = 1'b0; end
      begin drive_b(2'd1, 32'hBBBB_BBBB, ok_b); req_b = 1'b0; end
    join
    @(posedge clk); #1;
    checks++; if (!(ok_a && ok_b)) begin errors++; $display("[TB] FAIL simul_timeout got=%b%b exp=11", ok_a, ok_b); end
    n = 0; prev = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL simul_gnt_missing got=none exp=%0d", e); end
      else begin
        g = obs_q.pop_front();
        if (g.is_b !== e || (n > 0 && g.cyc != prev + 1)) begin
          errors++; $display("[TB] FAIL simul_gnt%0d got=%0d@%0d exp=%0d@%0d", n, g.is_b, g.cyc, e, prev + 1);
        end
        prev = g.cyc;
      end
      n++;
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL simul_gnt_extra got=%0d exp=0", obs_q.size()); end
    checks++; if (last_b !== 1'b1) begin errors++; $display("[TB] FAIL simul_last_b got=%b exp=1", last_b); end
    rd_exp_q.push_back(32'hBBBB_BBBB);
    do_read(2'd1, got);
    exp = rd_exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL simul_read got=%h exp=%h", got, exp); end
  endtask

  task automatic test_contention();
    int bad_a, bad_b, prev, n; bit e; grant_t g;
    logic [31:0] got, exp;
    obs_q.delete();
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 40; i++) exp_q.push_back(i[0]);
    fork
      begin
        bit ok;
        for (int i = 1; i <= 20; i++) begin drive_a(2'd0, i, ok); if (!ok) bad_a++; end
        req_a = 1'b0;
      end
      begin
        bit ok;
        for (int i = 1; i <= 20; i++) begin drive_b(2'd3, i, ok); if (!ok) bad_b++; end
        req_b = 1'b0;
      end
    join
    @(posedge clk); #1;
    checks++; if (bad_a + bad_b != 0) begin errors++; $display("[TB] FAIL cont_timeouts got=%0d exp=0", bad_a + bad_b); end
    n = 0; prev = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL cont_gnt_missing got=none exp=%0d", e); end
      else begin
        g = obs_q.pop_front();
        if (g.is_b !== e || (n > 0 && g.cyc != prev + 1)) begin
          errors++; $display("[TB] FAIL cont_gnt%0d got=%0d@%0d exp=%0d@%0d", n, g.is_b, g.cyc, e, prev + 1);
        end
        prev = g.cyc;
      end
      n++;
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL cont_gnt_extra got=%0d exp=0", obs_q.size()); end
    rd_exp_q.push_back(32'd20);
    rd_exp_q.push_back(32'd20);
    do_read(2'd0, got);
    exp = rd_exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL cont_reg0 got=%h exp=%h", got, exp); end
    do_read(2'd3, got);
    exp = rd_exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL cont_reg3 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_bypass();
    bit ok;
    logic [31:0] at_commit, after_commit, exp;
    obs_q.delete();
`ifdef WRITE_BYPASS_EN
    rd_exp_q.push_back(32'h1234_5678);
`else
    rd_exp_q.push_back(32'd20);
`endif
    rd_exp_q.push_back(32'h1234_5678);
    ok = 1'b0; at_commit = '0;
    rd_addr = 2'd0;
    req_b = 1'b1; addr_b = 2'd0; data_b = 32'h1234_5678;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #1;
      if (gnt_b === 1'b1) begin ok = 1'b1; at_commit = rd_data; end
    end
    req_b = 1'b0;
    @(posedge clk); #1;
    after_commit = rd_data;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bypass_gnt_timeout got=0 exp=1"); end
    exp = rd_exp_q.pop_front();
    checks++; if (at_commit !== exp) begin errors++; $display("[TB] FAIL bypass_commit_edge got=%h exp=%h", at_commit, exp); end
    exp = rd_exp_q.pop_front();
    checks++; if (after_commit !== exp) begin errors++; $display("[TB] FAIL bypass_next_edge got=%h exp=%h", after_commit, exp); end
  endtask

  task automatic test_reset_mid();
    bit ok_a, ok_b, e; grant_t g;
    logic [31:0] got, exp;
    drive_a(2'd2, 32'd77, ok_a);
    req_a = 1'b0;
    @(posedge clk); #1;
    req_a = 1'b1; addr_a = 2'd1; data_a = 32'd11;
    req_b = 1'b1; addr_b = 2'd2; data_b = 32'd22;
    @(posedge clk); #1;
    checks++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_pre_gnt got=a%b b%b exp=a0 b1", gnt_a, gnt_b); end
    #1 rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    #1;
    checks++; if (gnt_b !== 1'b0 || last_b !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_reset got=b%b last%b exp=b0 last1", gnt_b, last_b); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (gnt_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_gnt_a got=%b exp=0", gnt_a); end
    end
    for (int i = 0; i < 4; i++) begin
      rd_exp_q.push_back(32'h0);
      do_read(i[1:0], got);
      exp = rd_exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL mid_reg%0d got=%h exp=%h", i, got, exp); end
    end
    obs_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    fork
      begin drive_a(2'd1, 32'd11, ok_a); req_a = 1'b0; end
      begin drive_b(2'd2, 32'd22, ok_b); req_b = 1'b0; end
    join
    @(posedge clk); #1;
    checks++; if (!(ok_a && ok_b)) begin errors++; $display("[TB] FAIL mid_rereq_timeout got=%b%b exp=11", ok_a, ok_b); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL mid_gnt_missing got=none exp=%0d", e); end
      else begin
        g = obs_q.pop_front();
        if (g.is_b !== e) begin errors++; $display("[TB] FAIL mid_gnt_who got=%0d exp=%0d", g.is_b, e); end
      end
    end
    rd_exp_q.push_back(32'd11);
    do_read(2'd1, got);
    exp = rd_exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL mid_reg1_final got=%h exp=%h", got, exp); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single_writer();
    test_simultaneous();
    test_contention();
    test_bypass();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
